fp_add_arbiter: RTL

FP_ADD_ARBITER -- requirements
Module: fp_add_arbiter

---
 rtl/fp_add_arbiter_if.sv | 36 +++
 rtl/fp_add_arbiter.sv | 127 ++++++++++++
 2 files changed

// File: rtl/fp_add_arbiter_if.sv
// Requester, shared-adder and response signals of fp_add_arbiter.
// The slave modport is the arbiter's view. The master modport is the environment's view.
interface fp_add_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic        issue_valid;
  logic [31:0] issue_a;
  logic [31:0] issue_b;
  logic [31:0] result;
  logic        rsp0_valid;
  logic        rsp0_ready;
  logic [31:0] rsp0_data;
  logic        rsp1_valid;
  logic        rsp1_ready;
  logic [31:0] rsp1_data;

  modport slave (
    input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
    input  result, rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready, issue_valid, issue_a, issue_b,
    output rsp0_valid, rsp0_data, rsp1_valid, rsp1_data
  );

  modport master (
    output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
    output result, rsp0_ready, rsp1_ready,
    input  req0_ready, req1_ready, issue_valid, issue_a, issue_b,
    input  rsp0_valid, rsp0_data, rsp1_valid, rsp1_data
  );
endinterface

// File: rtl/fp_add_arbiter.sv
// Two-requester round-robin front end for a shared fixed-latency FP adder.
// Each requester has a credit-protected in-order response FIFO.
module fp_add_arbiter #(
  parameter int LATENCY   = 3,
  parameter int RSP_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  fp_add_arbiter_if.slave bus
);
  localparam int PW = $clog2(RSP_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(RSP_DEPTH);

  typedef enum logic {PRIO_REQ0 = 1'b0, PRIO_REQ1 = 1'b1} prio_e;

  logic [1:0]         req_valid, rsp_ready, elig, take, push, pop;
  logic [31:0]        req_a [2];
  logic [31:0]        req_b [2];
  logic               grant_id, hs;
  prio_e              prio_q, prio_d;
  logic [CW-1:0]      credit_q [2];
  logic [CW-1:0]      credit_d [2];
  logic [CW-1:0]      count_q [2];
  logic [CW-1:0]      count_d [2];
  logic [PW-1:0]      wr_q [2];
  logic [PW-1:0]      rd_q [2];
  logic [31:0]        mem_q [2][RSP_DEPTH];
  logic               issue_valid_q, issue_id_q;
  logic [31:0]        issue_a_q, issue_b_q;
  logic [LATENCY-1:0] tag_v_q, tag_id_q;

  assign req_valid = {bus.req1_valid, bus.req0_valid};
  assign rsp_ready = {bus.rsp1_ready, bus.rsp0_ready};
  assign req_a[0]  = bus.req0_a;
  assign req_a[1]  = bus.req1_a;
  assign req_b[0]  = bus.req0_b;
  assign req_b[1]  = bus.req1_b;

  // NOTE: every signal written here gets a value on every path (defaults first), so no latches are inferred.
  always_comb begin
    for (int n = 0; n < 2; n++) begin
      elig[n] = !rst && req_valid[n] && (credit_q[n] != '0);
    end
    hs       = |elig;
    grant_id = (elig == 2'b11) ? (prio_q == PRIO_REQ1) : elig[1];
    take     = {hs && grant_id, hs && !grant_id};
    prio_d   = prio_q;
    if (hs) prio_d = grant_id ? PRIO_REQ0 : PRIO_REQ1;

    push[0] = tag_v_q[LATENCY-1] && !tag_id_q[LATENCY-1];
    push[1] = tag_v_q[LATENCY-1] &&  tag_id_q[LATENCY-1];
    for (int n = 0; n < 2; n++) begin
      pop[n]      = (count_q[n] != '0) && rsp_ready[n];
      credit_d[n] = credit_q[n];
      if (take[n] && !pop[n])      credit_d[n] = credit_q[n] - CW'(1);
      else if (!take[n] && pop[n]) credit_d[n] = credit_q[n] + CW'(1);
      count_d[n] = count_q[n];
      if (push[n] && !pop[n])      count_d[n] = count_q[n] + CW'(1);
      else if (!push[n] && pop[n]) count_d[n] = count_q[n] - CW'(1);
    end
  end

  assign bus.req0_ready = elig[0] && !grant_id;
  assign bus.req1_ready = elig[1] &&  grant_id;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q        <= PRIO_REQ0;
      issue_valid_q <= 1'b0;
      issue_id_q    <= 1'b0;
      issue_a_q     <= '0;
      issue_b_q     <= '0;
      tag_v_q       <= '0;
      tag_id_q      <= '0;
      for (int n = 0; n < 2; n++) begin
        credit_q[n] <= DEPTH_C;
        count_q[n]  <= '0;
        wr_q[n]     <= '0;
        rd_q[n]     <= '0;
      end
    end else begin
      prio_q        <= prio_d;
      issue_valid_q <= hs;
      if (hs) begin
        issue_a_q  <= req_a[grant_id];
        issue_b_q  <= req_b[grant_id];
        issue_id_q <= grant_id;
      end
      // Tag leaves the last stage in the same cycle the adder presents its sum.
      tag_v_q[0]  <= issue_valid_q;
      tag_id_q[0] <= issue_id_q;
      for (int k = 1; k < LATENCY; k++) begin
        tag_v_q[k]  <= tag_v_q[k-1];
        tag_id_q[k] <= tag_id_q[k-1];
      end
      for (int n = 0; n < 2; n++) begin
        credit_q[n] <= credit_d[n];
        count_q[n]  <= count_d[n];
        if (push[n]) wr_q[n] <= wr_q[n] + PW'(1);
        if (pop[n])  rd_q[n] <= rd_q[n] + PW'(1);
      end
    end
  end

  // NOTE: response storage has no reset; the occupancy counters alone decide which entries are live.
  always_ff @(posedge clk) begin
    for (int n = 0; n < 2; n++) begin
      if (push[n]) mem_q[n][wr_q[n]] <= bus.result;
    end
  end

  assign bus.issue_valid = issue_valid_q;
  assign bus.issue_a     = issue_a_q;
  assign bus.issue_b     = issue_b_q;
  assign bus.rsp0_valid  = (count_q[0] != '0);
  assign bus.rsp1_valid  = (count_q[1] != '0);
  assign bus.rsp0_data   = bus.rsp0_valid ? mem_q[0][rd_q[0]] : '0;
  assign bus.rsp1_data   = bus.rsp1_valid ? mem_q[1][rd_q[1]] : '0;

  // The credit scheme must make a push into a full FIFO impossible.
  for (genvar n = 0; n < 2; n++) begin : g_full_chk
    a_no_push_full: assert property (@(posedge clk) disable iff (rst)
      !(push[n] && (count_q[n] == DEPTH_C)));
  end
endmodule
